// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - BCD limits shared by the minute and hour stages of the clock
package clock_pkg;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] MIN_TENS_WRAP = 4'd5;
  localparam logic [3:0] H24_TOP_TENS  = 4'd2;
  localparam logic [3:0] H24_TOP_UNITS = 4'd3;
  localparam int         H12_TOP       = 12;

  localparam logic [3:0] H12_TOP_TENS  = 4'(H12_TOP / 10);
  localparam logic [3:0] H12_TOP_UNITS = 4'(H12_TOP % 10);

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - rising-edge detector on a clk-synchronous level
module edge_rise (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_in;
    end
  end

  assign o_rise = i_in & ~r_d;

endmodule

// File: rtl/contador_horas.sv
// rtl/contador_horas.sv - BCD hours counter advanced by minute rollover or adjust button
module contador_horas
  import clock_pkg::*;
#(
  parameter bit MODE_24H = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] min_tens,
  input  logic       adj_hour,
  output logic [3:0] hour_units,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic       day_tick
);

  localparam logic [3:0] RST_UNITS = MODE_24H ? 4'd0 : H12_TOP_UNITS;
  localparam logic [1:0] RST_TENS  = MODE_24H ? 2'd0 : H12_TOP_TENS[1:0];

  logic [3:0] r_prev_mt;
  logic [3:0] r_units;
  logic [1:0] r_tens;
  logic       r_pm;
  logic       r_day_tick;

  logic       w_hour_evt;
  logic       w_adj_evt;
  logic       w_inc;
  logic [3:0] w_tens4;
  logic       w_illegal;
  logic       w_top;
  logic       w_eleven;

  edge_rise u_adj_edge (
    .i_clk   (clk),
    .i_rst_n (clear),
    .i_in    (adj_hour),
    .o_rise  (w_adj_evt)
  );

  assign w_hour_evt = (r_prev_mt == MIN_TENS_WRAP) && (min_tens == 4'd0);
  assign w_inc      = w_hour_evt | w_adj_evt;
  assign w_tens4    = {2'b00, r_tens};

  // In 12h mode 00 is not a legal hour, so it is folded into the illegal set.
  always_comb begin
    w_illegal = 1'b0;
    w_top     = 1'b0;
    w_eleven  = 1'b0;
    if (MODE_24H) begin
      w_illegal = (r_units > BCD_MAX_UNITS) || (w_tens4 > H24_TOP_TENS) ||
                  ((w_tens4 == H24_TOP_TENS) && (r_units > H24_TOP_UNITS));
      w_top     = (w_tens4 == H24_TOP_TENS) && (r_units == H24_TOP_UNITS);
    end else begin
      w_illegal = (r_units > BCD_MAX_UNITS) || (w_tens4 > H12_TOP_TENS) ||
                  ((w_tens4 == H12_TOP_TENS) && (r_units > H12_TOP_UNITS)) ||
                  ((w_tens4 == 4'd0) && (r_units == 4'd0));
      w_top     = (w_tens4 == H12_TOP_TENS) && (r_units == H12_TOP_UNITS);
      w_eleven  = (w_tens4 == H12_TOP_TENS) && (r_units == H12_TOP_UNITS - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_prev_mt  <= 4'd0;
      r_units    <= RST_UNITS;
      r_tens     <= RST_TENS;
      r_pm       <= 1'b0;
      r_day_tick <= 1'b0;
    end else begin
      r_prev_mt  <= min_tens;
      r_day_tick <= 1'b0;
      if (w_inc) begin
        if (w_illegal) begin
          r_units <= RST_UNITS;
          r_tens  <= RST_TENS;
          r_pm    <= 1'b0;
        end else if (w_top) begin
          if (MODE_24H) begin
            r_units    <= 4'd0;
            r_tens     <= 2'd0;
            r_day_tick <= w_hour_evt;
          end else begin
            r_units <= 4'd1;
            r_tens  <= 2'd0;
          end
        end else if (w_eleven) begin
          // 11 -> 12 flips AM/PM; only the PM-to-AM flip is a new day.
          r_units    <= H12_TOP_UNITS;
          r_tens     <= H12_TOP_TENS[1:0];
          r_pm       <= ~r_pm;
          r_day_tick <= w_hour_evt & r_pm;
        end else if (r_units == BCD_MAX_UNITS) begin
          r_units <= 4'd0;
          r_tens  <= r_tens + 2'd1;
        end else begin
          r_units <= r_units + 4'd1;
        end
      end
    end
  end

  assign hour_units = r_units;
  assign hour_tens  = w_tens4;
  assign pm         = MODE_24H ? 1'b0 : r_pm;
  assign day_tick   = r_day_tick;

endmodule
